// File: rtl/guess_game_ctrl.sv
// guess_game_ctrl: guess-the-number round sequencer (target capture, guess handshake, hints, win/loss)
module guess_game_ctrl #(
  parameter int WIDTH     = 4,
  parameter int MAX_TRIES = 5,
  parameter int CNT_W     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] lfsr_out,
  output logic             lfsr_en,
  input  logic [WIDTH-1:0] guess,
  input  logic             guess_valid,
  output logic             guess_ready,
  output logic [WIDTH-1:0] target,
  output logic             too_high,
  output logic             too_low,
  output logic             correct,
  output logic [CNT_W-1:0] attempts,
  output logic             done,
  output logic             win,
  output logic [2:0]       state
);
  typedef enum logic [2:0] {IDLE = 3'd0, PLAY = 3'd1, CHECK = 3'd2, WIN = 3'd3, LOSE = 3'd4} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] target_q, guess_q;
  logic [CNT_W-1:0] attempts_q;
  logic             too_high_q, too_low_q, correct_q, done_q, win_q;
  logic [CNT_W-1:0] attempts_d;
  assign attempts_d = attempts_q + CNT_W'(1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      target_q   <= '0;
      guess_q    <= '0;
      attempts_q <= '0;
      too_high_q <= 1'b0;
      too_low_q  <= 1'b0;
      correct_q  <= 1'b0;
      done_q     <= 1'b0;
      win_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE, WIN, LOSE: if (start) begin
          state_q    <= PLAY;
          target_q   <= lfsr_out;
          attempts_q <= '0;
          too_high_q <= 1'b0;
          too_low_q  <= 1'b0;
          correct_q  <= 1'b0;
          done_q     <= 1'b0;
          win_q      <= 1'b0;
        end
        PLAY: if (guess_valid) begin
          guess_q <= guess;
          state_q <= CHECK;
        end
        CHECK: begin
          too_high_q <= guess_q > target_q;
          too_low_q  <= guess_q < target_q;
          correct_q  <= guess_q == target_q;
          attempts_q <= attempts_d;
          if (guess_q == target_q) begin
            state_q <= WIN;
            done_q  <= 1'b1;
            win_q   <= 1'b1;
          end else if (attempts_d == CNT_W'(MAX_TRIES)) begin
            state_q <= LOSE;
            done_q  <= 1'b1;
            win_q   <= 1'b0;
          end else begin
            state_q <= PLAY;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  // LFSR free-runs only between rounds so the target stays unpredictable
  assign lfsr_en     = (state_q == IDLE) || (state_q == WIN) || (state_q == LOSE);
  assign guess_ready = state_q == PLAY;
  assign target      = target_q;
  assign too_high    = too_high_q;
  assign too_low     = too_low_q;
  assign correct     = correct_q;
  assign attempts    = attempts_q;
  assign done        = done_q;
  assign win         = win_q;
  assign state       = state_q;
endmodule

// File: tb/tb_guess_game_ctrl.sv
// tb_guess_game_ctrl: vector table, directed corner sequences and randomized play against a round model
module tb_guess_game_ctrl;
  localparam int MAX = 5;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, guess_valid = 1'b0;
  logic [3:0] lfsr_out = 4'd1, guess = 4'd0;
  logic lfsr_en, guess_ready, too_high, too_low, correct, done, win;
  logic [3:0] target;
  logic [2:0] attempts, state;
  int total = 0, bad = 0;

  guess_game_ctrl #(.WIDTH(4), .MAX_TRIES(MAX), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .lfsr_out(lfsr_out), .lfsr_en(lfsr_en),
    .guess(guess), .guess_valid(guess_valid), .guess_ready(guess_ready), .target(target),
    .too_high(too_high), .too_low(too_low), .correct(correct), .attempts(attempts),
    .done(done), .win(win), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       st;
    logic [3:0] lf;
    logic       gv;
    logic [3:0] g;
    logic [17:0] exp;
  } vec_t;

  function automatic logic [17:0] mk(int st, int tg, int at, logic [2:0] hint, logic dn, logic wn);
    logic en, rdy;
    en  = (st == 0) || (st == 3) || (st == 4);
    rdy = st == 1;
    return {st[2:0], tg[3:0], at[2:0], hint, dn, wn, en, rdy};
  endfunction

  function automatic logic [17:0] obs();
    return {state, target, attempts, too_high, too_low, correct, done, win, lfsr_en, guess_ready};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // round model: phase follows the externally visible state codes
  int m_phase, m_target, m_guess, m_att;
  logic [2:0] m_hint;
  logic m_done, m_win;

  task automatic model_step(logic st, int lf, logic gv, int g);
    if (m_phase == 0 || m_phase == 3 || m_phase == 4) begin
      if (st) begin
        m_target = lf; m_att = 0; m_hint = 3'b000; m_done = 0; m_win = 0; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (gv) begin
        m_guess = g; m_phase = 2;
      end
    end else begin
      m_att = m_att + 1;
      m_hint = (m_guess > m_target) ? 3'b100 : (m_guess < m_target) ? 3'b010 : 3'b001;
      if (m_guess == m_target) begin
        m_phase = 3; m_done = 1; m_win = 1;
      end else if (m_att == MAX) begin
        m_phase = 4; m_done = 1; m_win = 0;
      end else m_phase = 1;
    end
  endtask

  initial begin
    vec_t tbl[12];
    int acc;
    tbl[0]  = '{1'b0, 4'd7, 1'b0, 4'd0,  mk(0, 0, 0, 3'b000, 0, 0)};
    tbl[1]  = '{1'b0, 4'd2, 1'b1, 4'd5,  mk(0, 0, 0, 3'b000, 0, 0)};
    tbl[2]  = '{1'b1, 4'd9, 1'b1, 4'd9,  mk(1, 9, 0, 3'b000, 0, 0)};
    tbl[3]  = '{1'b0, 4'd4, 1'b1, 4'd3,  mk(2, 9, 0, 3'b000, 0, 0)};
    tbl[4]  = '{1'b0, 4'd4, 1'b0, 4'd0,  mk(1, 9, 1, 3'b010, 0, 0)};
    tbl[5]  = '{1'b0, 4'd4, 1'b1, 4'd12, mk(2, 9, 1, 3'b010, 0, 0)};
    tbl[6]  = '{1'b0, 4'd4, 1'b0, 4'd0,  mk(1, 9, 2, 3'b100, 0, 0)};
    tbl[7]  = '{1'b0, 4'd4, 1'b1, 4'd9,  mk(2, 9, 2, 3'b100, 0, 0)};
    tbl[8]  = '{1'b0, 4'd4, 1'b0, 4'd0,  mk(3, 9, 3, 3'b001, 1, 1)};
    tbl[9]  = '{1'b0, 4'd4, 1'b0, 4'd0,  mk(3, 9, 3, 3'b001, 1, 1)};
    tbl[10] = '{1'b1, 4'd6, 1'b1, 4'd6,  mk(1, 6, 0, 3'b000, 0, 0)};
    tbl[11] = '{1'b1, 4'd3, 1'b0, 4'd0,  mk(1, 6, 0, 3'b000, 0, 0)};
    #2;
    chk("reset_obs", 32'(obs()), 32'(mk(0, 0, 0, 3'b000, 0, 0)));
    @(negedge clk);
    rst = 1'b0;
    tick();
    foreach (tbl[i]) begin
      start = tbl[i].st; lfsr_out = tbl[i].lf; guess_valid = tbl[i].gv; guess = tbl[i].g;
      tick();
      chk($sformatf("vec%0d", i), 32'(obs()), 32'(tbl[i].exp));
    end
    start = 0; guess_valid = 0;
    // guess_valid held for 6 cycles: one guess per PLAY visit
    acc = 0;
    guess_valid = 1; guess = 4'd1;
    for (int i = 0; i < 6; i++) begin
      if (guess_ready) acc++;
      tick();
    end
    guess_valid = 0;
    chk("held_valid_accepts", acc, 3);
    chk("held_valid_attempts", attempts, 3);
    chk("held_valid_target", target, 6);
    guess_valid = 1; guess = 4'd6; tick(); guess_valid = 0; tick();
    chk("win_state", state, 3);
    // restart from WIN, then the target must not follow the LFSR
    start = 1; lfsr_out = 4'd9; tick(); start = 0;
    chk("capture_lfsr_en", lfsr_en, 0);
    for (int i = 0; i < 20; i++) begin
      lfsr_out = 4'($urandom_range(1, 15));
      tick();
    end
    chk("hold_target", target, 9);
    chk("hold_state", state, 1);
    for (int i = 0; i < 5; i++) begin
      guess_valid = 1; guess = 4'd1; tick(); guess_valid = 0; tick();
    end
    chk("loss_obs", 32'(obs()), 32'(mk(4, 9, 5, 3'b010, 1, 0)));
    for (int i = 0; i < 3; i++) begin
      guess_valid = 1; guess = 4'd9;
      chk($sformatf("lose_ready%0d", i), guess_ready, 0);
      tick();
      guess_valid = 0; tick();
    end
    chk("lose_attempts_hold", attempts, 5);
    chk("lose_state_hold", state, 4);
    // async reset while a guess is being checked
    start = 1; lfsr_out = 4'd5; tick(); start = 0;
    guess_valid = 1; guess = 4'd2; tick(); guess_valid = 0; tick();
    chk("pre_reset_attempts", attempts, 1);
    guess_valid = 1; guess = 4'd7; tick(); guess_valid = 0;
    chk("pre_reset_check", state, 2);
    #2 rst = 1;
    #1 chk("async_reset_obs", 32'(obs()), 32'(mk(0, 0, 0, 3'b000, 0, 0)));
    @(negedge clk);
    rst = 0;
    tick();
    chk("post_reset_idle", state, 0);
    // randomized play against the model
    m_phase = 0; m_target = 0; m_guess = 0; m_att = 0; m_hint = 0; m_done = 0; m_win = 0;
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      lfsr_out = 4'($urandom_range(1, 15));
      guess_valid = $urandom_range(0, 1) == 1;
      guess = 4'($urandom_range(0, 15));
      model_step(start, int'(lfsr_out), guess_valid, int'(guess));
      tick();
      if (obs() !== mk(m_phase, m_target, m_att, m_hint, m_done, m_win)) begin
        bad++;
        $display("FAIL rand%0d: got %0h want %0h", i, obs(), mk(m_phase, m_target, m_att, m_hint, m_done, m_win));
      end
      total++;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
